sync_fifo_ctrl: RTL and testbench
=================================

// Module: sync_fifo_ctrl
// PURPOSE
// - Parametrised single-clock FIFO: data width, depth and almost-full/empty thresholds configurable.
// - Active-low read/write strobes and registered read data.
// - Sticky overflow/underflow error flags with explicit clear.
// - Drop-in buffer between producer/consumer stages on one clock; the existing reset/overflow/underflow
//   properties bind to it directly (default DEPTH=16).
// PARAMETERS
// - DATA_W    8                 data word width, >=1
// - DEPTH     16                entries; power of 2, >=2
// - AF_LEVEL  DEPTH-2           almost_full asserted when count >= AF_LEVEL (1..DEPTH)
// - AE_LEVEL  2                 almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
// - ADDR_W    $clog2(DEPTH)     derived, do not override
// - CNT_W     $clog2(DEPTH+1)   derived, do not override
// PORTS
// - clk           in   1        clock, rising edge
// - rst_n         in   1        asynchronous active-low reset
// - wr_n          in   1        write strobe, active low
// - din           in   DATA_W   write data, sampled when wr_n=0
// - rd_n          in   1        read strobe, active low
// - dout          out  DATA_W   read data, registered
// - full          out  1        count == DEPTH
// - empty         out  1        count == 0
// - almost_full   out  1        count >= AF_LEVEL
// - almost_empty  out  1        count <= AE_LEVEL
// - count         out  CNT_W    current occupancy, 0..DEPTH
// - over_flow     out  1        sticky: a write was dropped because FIFO full
// - under_flow    out  1        sticky: a read was refused because FIFO empty
// - err_clr       in   1        synchronous clear of over_flow/under_flow, active high
// BEHAVIOUR
// - Reset (rst_n=0, async): wr_ptr=rd_ptr=0, count=0, dout=0, empty=1, almost_empty=1, full=0,
//   almost_full=0, over_flow=0, under_flow=0.
// - Memory contents are not reset.
// - Pointers: ADDR_W+1 bits, wrap naturally mod 2*DEPTH.
// - full:  ptrs equal in address bits, MSBs differ.
// - empty: ptrs fully equal.
// - count is a registered up/down counter; it must equal wr_ptr-rd_ptr (verified by bench).
// - Write accepted when wr_n=0 and (!full or read accepted same cycle):
//   - mem[wr_ptr] <= din; wr_ptr+1.
// - Read accepted when rd_n=0 and !empty:
//   - dout <= mem[rd_ptr] at that edge (1-cycle latency, no fall-through); rd_ptr+1.
//   - dout holds its value at all other times.
// - Simultaneous rd+wr:
//   - Full: both accepted, count unchanged, no overflow.
//   - Empty: write accepted, read refused (underflow set), dout holds, count 0->1.
//   - Otherwise: both accepted, count unchanged.
// - Write refused (wr_n=0, full, no accepted read): data dropped, ptrs/count unchanged; over_flow<=1 next edge.
// - Read refused (rd_n=0, empty): ptrs/count/dout unchanged; under_flow<=1 next edge.
// - Flags stay set until err_clr=1 at a clock edge.
// - err_clr coincident with a new error event: set wins (flag stays 1).
// - All status outputs are registered or derived from registered state only; no combinational path from strobes.
// - Reset asserted mid-operation: all state returns to reset values immediately; in-flight accesses are lost.
// STRUCTURE
// - fifo_pkg:
//   - fifo_status_t: packed struct {full, empty, almost_full, almost_empty}.
//   - Function clog2_cnt(depth) for CNT_W.
// - Sub-module fifo_mem:
//   - DEPTH x DATA_W register array, one write port, one registered read port.
//   - Inputs: we, waddr, wdata, re, raddr. Output: rdata.
// - Top holds pointers, counter, flags and status logic.
// - Parameter legality checked by elaboration-time $error.
// TESTING
// - Reset: hold rst_n=0 with wr_n=rd_n=0 toggling -> count=0, empty=1, over_flow=under_flow=0,
//   dout=0 throughout.
// - Fill: 16 writes of 0x00..0x0F, then 1 more write 0xAA -> full=1 after 16th, over_flow=1 after 17th,
//   count=16; then 16 reads -> dout 0x00..0x0F in order (0xAA never appears), empty=1.
// - Underflow: read on empty -> under_flow=1, dout unchanged; err_clr=1 one cycle -> under_flow=0;
//   err_clr with new underflow same cycle -> stays 1.
// - Simultaneous: at count=16, rd+wr 0x55 -> count stays 16, over_flow=0, 0x55 read last;
//   at count=0, rd+wr 0x33 -> count=1, under_flow=1.
// - Thresholds/wrap: 40 cycles random rd/wr with DEPTH=16 -> almost_full iff count>=14,
//   almost_empty iff count<=2; pointers wrap, data order preserved vs scoreboard.
// - Async reset mid-burst at count=9 -> all outputs reset same cycle; next write/read pair returns the new data.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the single-clock FIFO controller.
// Status bundle, access classification and counter-width helper.
package fifo_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

    // Classification of what actually happens to occupancy on a given edge.
    typedef enum logic [1:0] {
        ACC_NONE = 2'b00,
        ACC_WR   = 2'b01,
        ACC_RD   = 2'b10,
        ACC_RDWR = 2'b11
    } fifo_acc_e;

    // Occupancy spans 0..depth inclusive, so one extra code point is needed.
    function automatic int unsigned clog2_cnt(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for sync_fifo_ctrl: one write port, one registered read port.
// Array contents are never reset; only the read register is.
module fifo_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Same-address read+write returns the old word, which is the oldest entry when full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy counter, status and sticky error flags.
// Active-low strobes, registered read data with one cycle of latency.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter int unsigned CNT_W    = clog2_cnt(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_n,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_n,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  count,
    output logic              over_flow,
    output logic              under_flow,
    input  logic              err_clr
);

    if (DATA_W < 1) begin : g_bad_data_w
        $error("sync_fifo_ctrl: DATA_W must be >= 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_ctrl: DEPTH must be a power of 2 and >= 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("sync_fifo_ctrl: AF_LEVEL must be in 1..DEPTH");
    end
    if (AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_ctrl: AE_LEVEL must be in 0..DEPTH-1");
    end
    if (ADDR_W != $clog2(DEPTH) || CNT_W != clog2_cnt(DEPTH)) begin : g_bad_derived
        $error("sync_fifo_ctrl: ADDR_W/CNT_W are derived and must not be overridden");
    end

    logic [ADDR_W:0]  wr_ptr;
    logic [ADDR_W:0]  rd_ptr;
    logic [CNT_W-1:0] cnt;
    fifo_status_t     st;
    fifo_acc_e        acc;
    logic             rd_ok;
    logic             wr_ok;
    logic             ovf_evt;
    logic             udf_evt;

    // Status depends only on registered pointers and counter, never on the strobes.
    always_comb begin
        st              = '0;
        st.empty        = (wr_ptr == rd_ptr);
        st.full         = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                          (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
        st.almost_full  = (cnt >= CNT_W'(AF_LEVEL));
        st.almost_empty = (cnt <= CNT_W'(AE_LEVEL));
    end

    // A write into a full FIFO is still accepted when a read frees a slot on the same edge.
    always_comb begin
        rd_ok   = !rd_n && !st.empty;
        wr_ok   = !wr_n && (!st.full || rd_ok);
        ovf_evt = !wr_n && st.full && !rd_ok;
        udf_evt = !rd_n && st.empty;
        acc     = fifo_acc_e'({rd_ok, wr_ok});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + (ADDR_W + 1)'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + (ADDR_W + 1)'(1);
            end
            unique case (acc)
                ACC_WR:  cnt <= cnt + CNT_W'(1);
                ACC_RD:  cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // A new error on the same edge as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            over_flow  <= 1'b0;
            under_flow <= 1'b0;
        end else begin
            if (ovf_evt) begin
                over_flow <= 1'b1;
            end else if (err_clr) begin
                over_flow <= 1'b0;
            end
            if (udf_evt) begin
                under_flow <= 1'b1;
            end else if (err_clr) begin
                under_flow <= 1'b0;
            end
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_ok),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (din),
        .re    (rd_ok),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (dout)
    );

    assign full         = st.full;
    assign empty        = st.empty;
    assign almost_full  = st.almost_full;
    assign almost_empty = st.almost_empty;
    assign count        = cnt;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Scoreboard bench for sync_fifo_ctrl (DEPTH=16, DATA_W=8).
// Driver updates a queue model per edge; a negedge monitor pops and compares.
module tb_sync_fifo_ctrl;

    localparam int DP = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_n = 1'b1;
    logic       rd_n = 1'b1;
    logic       err_clr = 1'b0;
    logic [7:0] din = '0;
    logic [7:0] dout;
    logic       full, empty, almost_full, almost_empty, over_flow, under_flow;
    logic [4:0] count;

    sync_fifo_ctrl #(
        .DATA_W   (8),
        .DEPTH    (16),
        .AF_LEVEL (14),
        .AE_LEVEL (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_n         (wr_n),
        .din          (din),
        .rd_n         (rd_n),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .over_flow    (over_flow),
        .under_flow   (under_flow),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp_dout = '0;
    bit         ovf_m = 1'b0;
    bit         udf_m = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        exp_dout = '0;
        ovf_m    = 1'b0;
        udf_m    = 1'b0;
    endtask

    task automatic step(input bit wr, input bit rd, input logic [7:0] d, input bit clr);
        int n;
        bit fm, em, rok, wok;
        wr_n    = !wr;
        rd_n    = !rd;
        din     = d;
        err_clr = clr;
        @(posedge clk);
        if (rst_n) begin
            n   = mq.size();
            fm  = (n == DP);
            em  = (n == 0);
            rok = rd && !em;
            wok = wr && (!fm || rok);
            if (rok) exp_q.push_back(mq.pop_front());
            if (wok) mq.push_back(d);
            if (wr && fm && !rok) ovf_m = 1'b1;
            else if (clr)         ovf_m = 1'b0;
            if (rd && em)         udf_m = 1'b1;
            else if (clr)         udf_m = 1'b0;
        end
        #2;
        wr_n    = 1'b1;
        rd_n    = 1'b1;
        err_clr = 1'b0;
    endtask

    initial begin : monitor
        logic [4:0] pd;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) exp_dout = exp_q.pop_front();
            chk("dout", dout, exp_dout);
            chk("count", count, mq.size());
            chk("full", full, mq.size() == DP);
            chk("empty", empty, mq.size() == 0);
            chk("almost_full", almost_full, mq.size() >= 14);
            chk("almost_empty", almost_empty, mq.size() <= 2);
            chk("over_flow", over_flow, ovf_m);
            chk("under_flow", under_flow, udf_m);
            pd = dut.wr_ptr - dut.rd_ptr;
            chk("ptr_diff", pd, mq.size());
        end
    end

    initial begin : driver
        model_reset();
        // Strobes toggle while reset is held; nothing may move.
        for (int i = 0; i < 6; i++) step(i[0], !i[0], 8'hF0 + 8'(i), 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
        chk("fill_full", full, 1);
        chk("fill_ovf_clear", over_flow, 0);
        step(1'b1, 1'b0, 8'hAA, 1'b0);
        chk("fill_ovf_set", over_flow, 1);
        chk("fill_count", count, 16);

        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("ovf_cleared", over_flow, 0);
        step(1'b1, 1'b1, 8'h55, 1'b0);
        chk("simul_full_count", count, 16);
        chk("simul_full_ovf", over_flow, 0);
        chk("simul_full_dout", dout, 8'h00);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("drain_empty", empty, 1);
        chk("drain_last", dout, 8'h55);

        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("udf_set", under_flow, 1);
        chk("udf_dout_hold", dout, 8'h55);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("udf_clr", under_flow, 0);
        step(1'b0, 1'b1, 8'h00, 1'b1);
        chk("udf_set_wins", under_flow, 1);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        step(1'b1, 1'b1, 8'h33, 1'b0);
        chk("simul_empty_count", count, 1);
        chk("simul_empty_udf", under_flow, 1);
        step(1'b0, 1'b1, 8'h00, 1'b1);
        chk("simul_empty_read", dout, 8'h33);

        for (int i = 0; i < 40; i++) begin
            if (i < 20) step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 8'($urandom), 1'b0);
            else        step($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, 8'($urandom), 1'b0);
        end

        for (int i = 0; i < 40 && mq.size() < 9; i++) step(1'b1, 1'b0, 8'hC0 + 8'(i), 1'b0);
        for (int i = 0; i < 40 && mq.size() > 9; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("pre_reset_count", count, 9);
        wr_n  = 1'b0;
        rd_n  = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_count", count, 0);
        chk("arst_empty", empty, 1);
        chk("arst_dout", dout, 0);
        chk("arst_ae", almost_empty, 1);
        chk("arst_flags", {over_flow, under_flow, full, almost_full}, 0);
        #1;
        rst_n = 1'b1;
        wr_n  = 1'b1;
        rd_n  = 1'b1;
        step(1'b1, 1'b0, 8'h77, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("post_reset_read", dout, 8'h77);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
